// File: rtl/kfpga_config_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
// The state enum and default parameter values live here so every block agrees on them.
package kfpga_config_pkg;

  localparam int DEFAULT_WORD_WIDTH   = 8;
  localparam int DEFAULT_CHAIN_BITS   = 216;  // 9 tiles x 24 bits
  localparam int DEFAULT_CLEAR_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } load_state_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/config_serializer.sv
// Word-to-bit serializer: holds one accepted word and shifts it out LSB first.
// The held count can be loaded below WORD_WIDTH so a truncated final word stops early.
module config_serializer
  import kfpga_config_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               load,
  input  logic [WORD_WIDTH-1:0]              word,
  input  logic [$clog2(WORD_WIDTH+1)-1:0]    load_bits,
  output logic                               bit_out,
  output logic                               active,
  output logic [$clog2(WORD_WIDTH+1)-1:0]    held
);

  localparam int HW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] shift_reg;
  logic [HW-1:0]         held_reg;

  // A load on the last-bit cycle takes priority: that bit is consumed this cycle anyway.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      shift_reg <= '0;
      held_reg  <= '0;
    end else if (load) begin
      shift_reg <= word;
      held_reg  <= load_bits;
    end else if (held_reg != '0) begin
      shift_reg <= shift_reg >> 1;
      held_reg  <= held_reg - HW'(1);
    end
  end

  assign bit_out = shift_reg[0];
  assign active  = (held_reg != '0);
  assign held    = held_reg;

endmodule

// File: rtl/config_loader.sv
// Streams a bitstream into a serial configuration chain: clear, shift CHAIN_BITS bits, done.
// Words are accepted only when the serializer can take one without a bubble or an overrun.
module config_loader
  import kfpga_config_pkg::*;
#(
  parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
  parameter int CHAIN_BITS   = DEFAULT_CHAIN_BITS,
  parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(CHAIN_BITS + 1);
  localparam int HW    = $clog2(WORD_WIDTH + 1);
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  load_state_t      state;
  logic [CNT_W-1:0] bit_count;
  logic [CLR_W-1:0] clear_count;

  logic             ser_bit;
  logic             ser_active;
  logic [HW-1:0]    ser_held;
  logic [HW-1:0]    load_bits;
  logic             accept;
  int               committed;
  int               remaining;

  config_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .flush     (state != LOAD),
    .load      (accept),
    .word      (word_in),
    .load_bits (load_bits),
    .bit_out   (ser_bit),
    .active    (ser_active),
    .held      (ser_held)
  );

  // committed: bits already shifted plus bits still waiting in the serializer.
  always_comb begin
    committed     = int'(bit_count) + int'(ser_held);
    config_enable = (state == LOAD) && ser_active;
    config_out    = config_enable && ser_bit;
    word_ready    = (state == LOAD) && (ser_held <= HW'(1)) && (committed < CHAIN_BITS);
    accept        = word_valid && word_ready;
    remaining     = CHAIN_BITS - int'(bit_count) - (config_enable ? 1 : 0);
    load_bits     = HW'(min_int(remaining, WORD_WIDTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bit_count     <= '0;
      clear_count   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      config_nreset <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= CLEAR;
            clear_count   <= '0;
            bit_count     <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            config_nreset <= 1'b0;
          end
        end
        CLEAR: begin
          if (clear_count == CLR_W'(CLEAR_CYCLES - 1)) begin
            state         <= LOAD;
            config_nreset <= 1'b1;
          end else begin
            clear_count <= clear_count + CLR_W'(1);
          end
        end
        LOAD: begin
          if (config_enable) begin
            bit_count <= bit_count + CNT_W'(1);
            // The bit shifting now is the final one; the next cycle is already DONE.
            if (bit_count == CNT_W'(CHAIN_BITS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, giving the bitstream word width in bits.
REQ-002 SHALL have parameter CHAIN_BITS, default 216, giving the total configuration chain length in bits (9 tiles x 24).
REQ-003 SHALL have parameter CLEAR_CYCLES, default 2, giving the number of cycles config_nreset is held low before loading.
REQ-004 SHALL have ports:
clock  in  1  sole clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to begin a full chain load
word_in  in  WORD_WIDTH  bitstream word
word_valid  in  1  word_in is valid
word_ready  out  1  word accepted when word_valid and word_ready are both high on the same edge
config_out  out  1  serial bit into the head of the chain (drives the first tile's config_in)
config_enable  out  1  chain shift enable, one bit per cycle when high
config_nreset  out  1  active-low chain clear
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Function
REQ-005 SHALL implement the FSM IDLE -> CLEAR -> LOAD -> DONE.
- IDLE: on start, go to CLEAR.
- CLEAR: after CLEAR_CYCLES cycles, go to LOAD.
- LOAD: when the bit counter reaches CHAIN_BITS, go to DONE.
- DONE: on start, go to CLEAR; otherwise stay.
REQ-006 In CLEAR, SHALL drive config_nreset=0 and config_enable=0; config_nreset SHALL be 1 in every other state.
REQ-007 In LOAD, SHALL hold the accepted word in a shift register and emit its bits LSB first on config_out, one bit per cycle, with config_enable=1 on exactly those cycles.
REQ-008 SHALL emit bits in arrival order, so the first bit received is the one pushed deepest into the chain.
REQ-009 word_ready SHALL be 1 only in LOAD, and only when both hold:
- the shift register is empty, or is emitting its last bit this cycle;
- the bits already emitted plus the bits still held are less than CHAIN_BITS.
REQ-010 A back-to-back word stream SHALL shift with zero bubble cycles.
REQ-011 If the shift register is empty and word_valid=0, SHALL drive config_enable=0 and hold the bit counter; the chain contents are then held.
REQ-012 The bit counter SHALL be $clog2(CHAIN_BITS+1) bits wide and SHALL increment only on cycles where config_enable=1.
REQ-013 If CHAIN_BITS is not a multiple of WORD_WIDTH, SHALL emit only the low (CHAIN_BITS mod WORD_WIDTH) bits of the final word and discard the rest.
REQ-014 SHALL drive config_enable=0 in the first cycle after the count reaches CHAIN_BITS.
REQ-015 SHALL ignore start while busy=1.
REQ-016 If start and a word handshake occur on the same edge, the word SHALL have no effect, because word_ready=0 outside LOAD.
REQ-017 When config_enable=0, config_out SHALL be 0.

Reset
REQ-018 On reset=1 at a rising edge, SHALL set all of the following regardless of state, abandoning any partial load:
- state to IDLE;
- bit counter and shift register to 0;
- config_out=0, config_enable=0, config_nreset=1;
- word_ready=0, busy=0, done=0.
REQ-019 The chain contents after a mid-load reset are undefined; a new start SHALL always clear the chain first via CLEAR.

Structure
REQ-020 SHALL place the FSM state enum (IDLE, CLEAR, LOAD, DONE) and the default parameter values in the shared package kfpga_config_pkg.
REQ-021 SHALL be a single module; the serializer datapath (shift register plus bit-in-word counter) may be the sub-module config_serializer.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Nominal load: start, then 27 words of 0xA5 streamed back-to-back -> config_nreset low for 2 cycles, then config_enable high for exactly 216 consecutive cycles; config_out sequence 1,0,1,0,0,1,0,1 repeating; done=1 on the next cycle.
- Gaps: word_valid low for 3 cycles between words 5 and 6 -> config_enable low for exactly 3 cycles; total enables still 216; a modelled 216-bit chain matches the stream.
- Truncation: CHAIN_BITS=20, WORD_WIDTH=8, words 0xFF, 0x00, 0x3C -> 20 enables; last four bits 0,0,1,1; word_ready=0 after the third word.
- Mid-load reset: reset after 100 enables -> next cycle all outputs at reset values; a following start passes through CLEAR and completes 216 enables.
- Start ignored / reload: start pulsed during LOAD -> no effect; start in DONE -> CLEAR entered, done=0, busy=1.
- Clear timing: CLEAR_CYCLES=4 -> config_nreset low for exactly 4 cycles with config_enable=0.
